// File: rtl/wb_trace_buf_if.sv
// Writeback-commit and trace-consumer signal bundle for wb_trace_buf.
// The master side is the core plus the trace consumer. The slave side is the trace buffer.
interface wb_trace_buf_if #(
    parameter int LANES = 1
);
    logic [LANES-1:0]      wb_have_inst;
    logic [32*LANES-1:0]   wb_pc;
    logic [LANES-1:0]      wb_ena;
    logic [5*LANES-1:0]    wb_reg;
    logic [32*LANES-1:0]   wb_value;

    logic                  trc_valid;
    logic                  trc_ready;
    logic [31:0]           trc_pc;
    logic                  trc_ena;
    logic [4:0]            trc_reg;
    logic [31:0]           trc_value;

    modport master (
        output wb_have_inst, wb_pc, wb_ena, wb_reg, wb_value, trc_ready,
        input  trc_valid, trc_pc, trc_ena, trc_reg, trc_value
    );

    modport slave (
        input  wb_have_inst, wb_pc, wb_ena, wb_reg, wb_value, trc_ready,
        output trc_valid, trc_pc, trc_ena, trc_reg, trc_value
    );
endinterface

// File: rtl/wb_trace_buf.sv
// Commit trace FIFO with drop accounting, commit counting and a self-loop halt detector.
// Lanes are stored oldest first. When slots run out, the youngest lanes are dropped.
//
// Halt detector states:
//   state  | meaning
//   S_IDLE | no commit seen since reset/clr; last_pc and repeat are not meaningful
//   S_RUN  | tracking repeat count of consecutive commits at last_pc
module wb_trace_buf #(
    parameter int LANES       = 1,
    parameter int DEPTH       = 16,
    parameter int HALT_REPEAT = 4,
    parameter int FILTER_X0   = 1
) (
    input  logic           fpga_clk,
    input  logic           fpga_rst,
    wb_trace_buf_if.slave  bus,
    input  logic           clr,
    output logic           trc_overflow,
    output logic [15:0]    drop_cnt,
    output logic [31:0]    commit_cnt,
    output logic           halt_det
);

    localparam int AW = $clog2(DEPTH);
    localparam int RW = $clog2(HALT_REPEAT + 1);
    localparam logic [RW-1:0] REP_MAX = RW'(HALT_REPEAT);

    typedef struct packed {
        logic [31:0] pc;
        logic        ena;
        logic [4:0]  rg;
        logic [31:0] value;
    } entry_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } hstate_t;

    entry_t          mem [DEPTH];
    entry_t          head;
    entry_t          wentry [LANES];
    logic [AW:0]     waddr [LANES];

    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;
    logic [AW:0]     occ;
    logic            empty;
    logic            pop;
    logic [AW+1:0]   free_slots;
    logic [AW+1:0]   n_store;
    logic [1:0]      n_drop;
    logic [1:0]      n_commit;
    logic [LANES-1:0] store;
    logic [16:0]     drop_sum;

    hstate_t         state;
    hstate_t         state_nxt;
    logic [31:0]     last_pc;
    logic [31:0]     last_pc_nxt;
    logic [RW-1:0]   rep;
    logic [RW-1:0]   rep_nxt;
    logic            halt_hit;

    assign empty      = (wr_ptr == rd_ptr);
    assign occ        = wr_ptr - rd_ptr;
    assign pop        = ~empty & bus.trc_ready;
    // A slot freed by this cycle's pop can be refilled in the same cycle.
    assign free_slots = (AW+2)'(DEPTH) - {1'b0, occ} + {{(AW+1){1'b0}}, pop};

    always_comb begin
        n_store  = '0;
        n_drop   = '0;
        n_commit = '0;
        store    = '0;
        for (int l = 0; l < LANES; l++) begin
            waddr[l]        = wr_ptr + n_store[AW:0];
            wentry[l].pc    = bus.wb_pc[32*l +: 32];
            wentry[l].rg    = bus.wb_reg[5*l +: 5];
            wentry[l].value = bus.wb_value[32*l +: 32];
            wentry[l].ena   = bus.wb_ena[l] &
                              ~((FILTER_X0 != 0) && (bus.wb_reg[5*l +: 5] == 5'd0));
            if (bus.wb_have_inst[l]) begin
                n_commit = n_commit + 2'd1;
                if (n_store < free_slots) begin
                    store[l] = 1'b1;
                    n_store  = n_store + (AW+2)'(1);
                end else begin
                    n_drop = n_drop + 2'd1;
                end
            end
        end
    end

    always_ff @(posedge fpga_clk) begin
        for (int l = 0; l < LANES; l++) begin
            if (store[l]) begin
                mem[waddr[l][AW-1:0]] <= wentry[l];
            end
        end
    end

    always_ff @(posedge fpga_clk or posedge fpga_rst) begin
        if (fpga_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr + n_store[AW:0];
            rd_ptr <= rd_ptr + {{AW{1'b0}}, pop};
        end
    end

    assign head          = mem[rd_ptr[AW-1:0]];
    assign bus.trc_valid = ~empty;
    assign bus.trc_pc    = head.pc;
    assign bus.trc_ena   = head.ena;
    assign bus.trc_reg   = head.rg;
    assign bus.trc_value = head.value;

    assign drop_sum = {1'b0, drop_cnt} + {15'd0, n_drop};

    always_ff @(posedge fpga_clk or posedge fpga_rst) begin
        if (fpga_rst) begin
            trc_overflow <= 1'b0;
            drop_cnt     <= '0;
            commit_cnt   <= '0;
            halt_det     <= 1'b0;
        end else if (clr) begin
            trc_overflow <= 1'b0;
            drop_cnt     <= '0;
            commit_cnt   <= '0;
            halt_det     <= 1'b0;
        end else begin
            commit_cnt <= commit_cnt + {30'd0, n_commit};
            if (n_drop != 2'd0) begin
                trc_overflow <= 1'b1;
            end
            drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            if (halt_hit) begin
                halt_det <= 1'b1;
            end
        end
    end

    always_ff @(posedge fpga_clk or posedge fpga_rst) begin
        if (fpga_rst) begin
            state   <= S_IDLE;
            last_pc <= '0;
            rep     <= '0;
        end else begin
            state   <= state_nxt;
            last_pc <= last_pc_nxt;
            rep     <= rep_nxt;
        end
    end

    // Lanes are walked in age order, so a two-lane self-loop counts twice in one cycle.
    always_comb begin
        state_nxt   = state;
        last_pc_nxt = last_pc;
        rep_nxt     = rep;
        halt_hit    = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            if (bus.wb_have_inst[l]) begin
                if (state_nxt == S_IDLE) begin
                    state_nxt   = S_RUN;
                    last_pc_nxt = bus.wb_pc[32*l +: 32];
                    rep_nxt     = RW'(1);
                end else if (bus.wb_pc[32*l +: 32] == last_pc_nxt) begin
                    if (rep_nxt < REP_MAX) begin
                        rep_nxt = rep_nxt + RW'(1);
                    end
                end else begin
                    last_pc_nxt = bus.wb_pc[32*l +: 32];
                    rep_nxt     = RW'(1);
                end
            end
        end
        halt_hit = (state_nxt == S_RUN) && (rep_nxt >= REP_MAX);
        if (clr) begin
            state_nxt   = S_IDLE;
            last_pc_nxt = '0;
            rep_nxt     = '0;
        end
    end

endmodule
